// File: rtl/apb_alu_master_if.sv
// ---------------------------------------------------------------------------
// apb_alu_master_if
// Bundles the three handshakes of the ALU APB initiator:
//   cmd_*  : command port, valid/ready (host -> initiator)
//   res_*  : response port, valid/ready (initiator -> host)
//   p*     : APB bus (initiator -> ALU CSR slave)
// modport master : the initiator's view (apb_alu_master)
// modport slave  : the surrounding environment's view (host + APB slave)
// ---------------------------------------------------------------------------
interface apb_alu_master_if #(
  parameter int APB_BUS_SIZE   = 32,
  parameter int OPERATION_SIZE = 2,
  parameter int ID_SIZE        = 8,
  parameter int FIFO_OUT_WIDTH = 25
);
  // command port
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [OPERATION_SIZE-1:0] cmd_op;
  logic [ID_SIZE-1:0]        cmd_id;
  logic [APB_BUS_SIZE-1:0]   cmd_data0;
  logic [APB_BUS_SIZE-1:0]   cmd_data1;
  // response port
  logic                      res_valid;
  logic                      res_ready;
  logic [FIFO_OUT_WIDTH-1:0] res_data;
  logic [ID_SIZE-1:0]        res_id;
  logic                      res_err;
  logic                      res_timeout;
  // APB
  logic [APB_BUS_SIZE-1:0]   paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [APB_BUS_SIZE-1:0]   pwdata;
  logic [APB_BUS_SIZE-1:0]   prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  cmd_valid, cmd_op, cmd_id, cmd_data0, cmd_data1,
    output cmd_ready,
    output res_valid, res_data, res_id, res_err, res_timeout,
    input  res_ready,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_id, cmd_data0, cmd_data1,
    input  cmd_ready,
    input  res_valid, res_data, res_id, res_err, res_timeout,
    output res_ready,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_alu_master.sv
// ---------------------------------------------------------------------------
// apb_alu_master
// APB initiator driving the ALU CSR slave. One command (op, id, two operands)
// is accepted on the cmd port; the block writes DATA_0, DATA_1, then CTRL with
// start set, polls STATUS until the FIFO_OUT-empty bit clears (bounded by
// POLL_MAX reads, POLL_GAP idle cycles apart), reads RESULT and presents it on
// the res port until consumed. A pslverr on any transfer aborts the command
// with res_err; exhausting the poll budget reports res_timeout.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : apb_alu_master_if.master (cmd_*, res_*, APB signals)
// ---------------------------------------------------------------------------
module apb_alu_master #(
  parameter int APB_BUS_SIZE   = 32,
  parameter int OPERATION_SIZE = 2,
  parameter int ID_SIZE        = 8,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int POLL_MAX       = 16,
  parameter int POLL_GAP       = 0
) (
  input  logic            clk,
  input  logic            rst,
  apb_alu_master_if.master bus
);

  localparam int PW       = $clog2(POLL_MAX + 1);
  localparam int GW       = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  localparam logic [APB_BUS_SIZE-1:0] ADDR_CTRL   = APB_BUS_SIZE'(32'h00);
  localparam logic [APB_BUS_SIZE-1:0] ADDR_DATA0  = APB_BUS_SIZE'(32'h04);
  localparam logic [APB_BUS_SIZE-1:0] ADDR_DATA1  = APB_BUS_SIZE'(32'h08);
  localparam logic [APB_BUS_SIZE-1:0] ADDR_RESULT = APB_BUS_SIZE'(32'h0C);
  localparam logic [APB_BUS_SIZE-1:0] ADDR_STATUS = APB_BUS_SIZE'(32'h10);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_RESP
  } state_t;

  typedef enum logic [2:0] {
    WR_D0, WR_D1, WR_CTRL, RD_STATUS, RD_RESULT
  } step_t;

  state_t                    state_q, state_d;
  step_t                     step_q, step_d;
  logic [PW-1:0]             poll_q, poll_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [OPERATION_SIZE-1:0] op_q, op_d;
  logic [ID_SIZE-1:0]        id_q, id_d;
  logic [APB_BUS_SIZE-1:0]   d0_q, d0_d;
  logic [APB_BUS_SIZE-1:0]   d1_q, d1_d;
  logic [FIFO_OUT_WIDTH-1:0] res_data_q, res_data_d;
  logic [ID_SIZE-1:0]        res_id_q, res_id_d;
  logic                      res_err_q, res_err_d;
  logic                      res_to_q, res_to_d;
  logic [APB_BUS_SIZE-1:0]   ctrl_word;
  logic [PW-1:0]             poll_inc;

  // Only the low FIFO_OUT_WIDTH bits and bit0 of prdata carry meaning.
  logic unused_prdata;
  assign unused_prdata = ^bus.prdata;

  // CTRL = {.., id at [15:8], op at [OPERATION_SIZE:1], start at bit0}
  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[0]                = 1'b1;
    ctrl_word[OPERATION_SIZE:1] = op_q;
    ctrl_word[8 +: ID_SIZE]     = id_q;
  end

  assign poll_inc = poll_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= WR_D0;
      poll_q     <= '0;
      gap_q      <= '0;
      op_q       <= '0;
      id_q       <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_err_q  <= 1'b0;
      res_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_q     <= poll_d;
      gap_q      <= gap_d;
      op_q       <= op_d;
      id_q       <= id_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      res_err_q  <= res_err_d;
      res_to_q   <= res_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_d     = poll_q;
    gap_d      = gap_q;
    op_d       = op_q;
    id_d       = id_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_err_d  = res_err_q;
    res_to_d   = res_to_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          id_d    = bus.cmd_id;
          d0_d    = bus.cmd_data0;
          d1_d    = bus.cmd_data1;
          poll_d  = '0;
          step_d  = WR_D0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: state_d = S_ACCESS;

      S_ACCESS: begin
        if (bus.pready) begin
          if (bus.pslverr) begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            res_id_d   = id_q;
            state_d    = S_RESP;
          end else begin
            case (step_q)
              WR_D0:   begin step_d = WR_D1;     state_d = S_SETUP; end
              WR_D1:   begin step_d = WR_CTRL;   state_d = S_SETUP; end
              WR_CTRL: begin step_d = RD_STATUS; state_d = S_SETUP; end
              RD_STATUS: begin
                if (bus.prdata[0]) begin
                  // FIFO_OUT still empty: count this poll, give up at the budget
                  poll_d = poll_inc;
                  if (poll_inc == PW'(POLL_MAX)) begin
                    res_to_d   = 1'b1;
                    res_data_d = '0;
                    res_id_d   = id_q;
                    state_d    = S_RESP;
                  end else if (POLL_GAP == 0) begin
                    state_d = S_SETUP;
                  end else begin
                    gap_d   = '0;
                    state_d = S_GAP;
                  end
                end else begin
                  step_d  = RD_RESULT;
                  state_d = S_SETUP;
                end
              end
              RD_RESULT: begin
                res_data_d = bus.prdata[FIFO_OUT_WIDTH-1:0];
                res_id_d   = id_q;
                state_d    = S_RESP;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = S_SETUP;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_RESP: begin
        if (bus.res_ready) begin
          res_data_d = '0;
          res_id_d   = '0;
          res_err_d  = 1'b0;
          res_to_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // APB and handshake outputs decode from the registered state, so a reset
  // edge removes psel/penable immediately.
  always_comb begin
    bus.cmd_ready   = (state_q == S_IDLE);
    bus.res_valid   = (state_q == S_RESP);
    bus.res_data    = res_data_q;
    bus.res_id      = res_id_q;
    bus.res_err     = res_err_q;
    bus.res_timeout = res_to_q;
    bus.psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    bus.penable     = (state_q == S_ACCESS);
    bus.paddr       = '0;
    bus.pwrite      = 1'b0;
    bus.pwdata      = '0;
    if (bus.psel) begin
      case (step_q)
        WR_D0:     begin bus.paddr = ADDR_DATA0; bus.pwrite = 1'b1; bus.pwdata = d0_q; end
        WR_D1:     begin bus.paddr = ADDR_DATA1; bus.pwrite = 1'b1; bus.pwdata = d1_q; end
        WR_CTRL:   begin bus.paddr = ADDR_CTRL;  bus.pwrite = 1'b1; bus.pwdata = ctrl_word; end
        RD_STATUS: bus.paddr = ADDR_STATUS;
        RD_RESULT: bus.paddr = ADDR_RESULT;
        default:   bus.paddr = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_alu_master.sv
// ---------------------------------------------------------------------------
// tb_apb_alu_master
// Directed and randomized commands against apb_alu_master with a configurable
// APB slave (wait states, error address, number of empty STATUS reads). The
// expected transfer list, setup-cycle offsets, latency and response are
// derived from the command and slave configuration alone.
// ---------------------------------------------------------------------------
module tb_apb_alu_master;
  localparam int AW = 32, OW = 2, IW = 8, FW = 25, PMAX = 4, PGAP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_alu_master_if #(.APB_BUS_SIZE(AW), .OPERATION_SIZE(OW), .ID_SIZE(IW),
                      .FIFO_OUT_WIDTH(FW)) bus ();

  apb_alu_master #(.APB_BUS_SIZE(AW), .OPERATION_SIZE(OW), .ID_SIZE(IW),
                   .FIFO_OUT_WIDTH(FW), .POLL_MAX(PMAX), .POLL_GAP(PGAP))
    dut (.clk(clk), .rst(rst), .bus(bus.master));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // slave configuration
  int          cfg_wait_addr = -1;
  int          cfg_wait_n    = 0;
  int          cfg_err_addr  = -1;
  int          cfg_empties   = 0;
  logic [31:0] cfg_result    = 32'h0;
  int          status_seen   = 0;

  // observed transfers
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_wdata[$];
  int          log_cyc[$];

  // expected transfers
  logic [31:0] exp_addr[$];
  logic        exp_wr[$];
  logic [31:0] exp_wdata[$];
  int          exp_off[$];
  int          m_dur;
  bit          m_done, m_err, m_to;
  logic [FW-1:0] m_data;

  int          wleft = 0;
  logic [31:0] rnd;

  initial begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
  end

  // APB slave model plus per-cycle bus discipline checks
  always @(negedge clk) begin
    if (rst || !bus.psel) begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = '0;
      if (!rst) begin
        check("idle_penable", bus.penable, 0);
        check("idle_paddr", bus.paddr, 0);
        check("idle_pwrite", bus.pwrite, 0);
        check("idle_pwdata", bus.pwdata, 0);
      end
    end else if (!bus.penable) begin
      log_addr.push_back(bus.paddr);
      log_wr.push_back(bus.pwrite);
      log_wdata.push_back(bus.pwdata);
      log_cyc.push_back(cyc);
      wleft       = (int'(bus.paddr) == cfg_wait_addr) ? cfg_wait_n : 0;
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
    end else begin
      check("hold_paddr", bus.paddr, log_addr[$]);
      check("hold_pwrite", bus.pwrite, log_wr[$]);
      check("hold_pwdata", bus.pwdata, log_wdata[$]);
      if (wleft > 0) begin
        wleft--;
        bus.pready = 1'b0;
      end else begin
        rnd         = $urandom;
        bus.pready  = 1'b1;
        bus.pslverr = (int'(bus.paddr) == cfg_err_addr);
        if (bus.paddr == 32'h10) begin
          bus.prdata  = {rnd[31:1], (status_seen < cfg_empties)};
          status_seen++;
        end else if (bus.paddr == 32'h0C) begin
          bus.prdata = cfg_result;
        end else begin
          bus.prdata = rnd;
        end
      end
    end
  end

  // reference model: expected transfer list from command + slave config
  task automatic m_add(input int a, input bit w, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_wr.push_back(w);
    exp_wdata.push_back(d);
    exp_off.push_back(m_dur);
    m_dur += 2 + ((a == cfg_wait_addr) ? cfg_wait_n : 0);
    if (a == cfg_err_addr) begin
      m_err  = 1'b1;
      m_done = 1'b1;
    end
  endtask

  task automatic build_expect(input logic [1:0] op, input logic [7:0] id,
                              input logic [31:0] d0, input logic [31:0] d1);
    int polls;
    exp_addr.delete(); exp_wr.delete(); exp_wdata.delete(); exp_off.delete();
    m_dur = 1; m_done = 0; m_err = 0; m_to = 0; m_data = '0;
    m_add(32'h04, 1, d0);
    if (!m_done) m_add(32'h08, 1, d1);
    if (!m_done) m_add(32'h00, 1, {16'b0, id, 5'b0, op, 1'b1});
    polls = 0;
    while (!m_done) begin
      if (polls > 0) m_dur += PGAP;
      m_add(32'h10, 0, 32'h0);
      if (m_done) break;
      polls++;
      if (polls <= cfg_empties) begin
        if (polls == PMAX) begin
          m_to   = 1'b1;
          m_done = 1'b1;
        end
      end else begin
        m_add(32'h0C, 0, 32'h0);
        if (!m_done) m_data = cfg_result[FW-1:0];
        m_done = 1'b1;
      end
    end
  endtask

  task automatic offer_cmd(input logic [1:0] op, input logic [7:0] id,
                           input logic [31:0] d0, input logic [31:0] d1, output int t);
    int k = 0;
    status_seen = 0;
    log_addr.delete(); log_wr.delete(); log_wdata.delete(); log_cyc.delete();
    @(negedge clk);
    while (!bus.cmd_ready && k < 50) begin @(negedge clk); k++; end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_id    = id;
    bus.cmd_data0 = d0;
    bus.cmd_data1 = d1;
    t = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("cmd_ready_busy", bus.cmd_ready, 0);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] id,
                         input logic [31:0] d0, input logic [31:0] d1, input int hold);
    int t, r, k;
    build_expect(op, id, d0, d1);
    offer_cmd(op, id, d0, d1, t);
    k = 0;
    while (!bus.res_valid && k < 400) begin @(negedge clk); k++; end
    r = cyc;
    check({name, "_res_valid"}, bus.res_valid, 1);
    check({name, "_latency"}, r - t, m_dur);
    check({name, "_res_data"}, bus.res_data, m_data);
    check({name, "_res_id"}, bus.res_id, id);
    check({name, "_res_err"}, bus.res_err, m_err);
    check({name, "_res_timeout"}, bus.res_timeout, m_to);
    repeat (hold) begin
      @(negedge clk);
      check({name, "_hold_valid"}, bus.res_valid, 1);
      check({name, "_hold_data"}, bus.res_data, m_data);
      check({name, "_hold_id"}, bus.res_id, id);
      check({name, "_hold_err"}, bus.res_err, m_err);
      check({name, "_hold_to"}, bus.res_timeout, m_to);
      check({name, "_hold_psel"}, bus.psel, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, "_clr_valid"}, bus.res_valid, 0);
    check({name, "_clr_data"}, bus.res_data, 0);
    check({name, "_clr_id"}, bus.res_id, 0);
    check({name, "_clr_flags"}, {bus.res_err, bus.res_timeout}, 0);
    check({name, "_cmd_ready_after"}, bus.cmd_ready, 1);
    check({name, "_n_xfers"}, log_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      check({name, "_xfer_addr"}, log_addr[i], exp_addr[i]);
      check({name, "_xfer_write"}, log_wr[i], exp_wr[i]);
      if (exp_wr[i]) check({name, "_xfer_wdata"}, log_wdata[i], exp_wdata[i]);
      check({name, "_xfer_setup_cycle"}, log_cyc[i] - t, exp_off[i]);
    end
  endtask

  task automatic set_cfg(input int wa, input int wn, input int ea, input int emp);
    cfg_wait_addr = wa;
    cfg_wait_n    = wn;
    cfg_err_addr  = ea;
    cfg_empties   = emp;
    cfg_result    = $urandom;
  endtask

  initial begin
    int t, k;
    int picks[6];
    picks = '{-1, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_id    = '0;
    bus.cmd_data0 = '0;
    bus.cmd_data1 = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_psel_penable", {bus.psel, bus.penable}, 0);
    check("rst_apb_out", {bus.paddr, bus.pwrite, bus.pwdata}, 0);
    check("rst_res", {bus.res_valid, bus.res_data, bus.res_id, bus.res_err, bus.res_timeout}, 0);
    rst = 1'b0;

    // zero-wait, first STATUS not empty
    set_cfg(-1, 0, -1, 0);
    run_cmd("basic", 2'd2, 8'h5A, 32'd3, 32'd4, 0);
    check("basic_latency_abs", m_dur, 11);

    // wait states on DATA_1
    set_cfg(32'h08, 3, -1, 0);
    run_cmd("wait_d1", 2'd1, 8'h11, $urandom, $urandom, 0);

    // two empty polls with gaps
    set_cfg(-1, 0, -1, 2);
    run_cmd("poll_gap", 2'd3, 8'h22, $urandom, $urandom, 1);

    // STATUS never clears
    set_cfg(-1, 0, -1, 100);
    run_cmd("timeout", 2'd0, 8'h33, $urandom, $urandom, 2);

    // slave error on CTRL, slow consumer
    set_cfg(-1, 0, 32'h00, 0);
    run_cmd("err_ctrl", 2'd2, 8'h44, $urandom, $urandom, 5);

    // reset during the STATUS access
    set_cfg(-1, 0, -1, 100);
    offer_cmd(2'd1, 8'h55, $urandom, $urandom, t);
    k = 0;
    while (!(bus.psel && bus.penable && bus.paddr == 32'h10) && k < 100) begin
      @(negedge clk); k++;
    end
    check("rst_mid_found_status", {bus.psel, bus.penable, (bus.paddr == 32'h10)}, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_psel_penable", {bus.psel, bus.penable}, 0);
    check("rst_mid_cmd_ready", bus.cmd_ready, 1);
    check("rst_mid_res_valid", bus.res_valid, 0);
    rst = 1'b0;
    set_cfg(-1, 0, -1, 1);
    run_cmd("after_rst", 2'd3, 8'h66, $urandom, $urandom, 0);

    // randomized commands
    for (int i = 0; i < 10; i++) begin
      set_cfg(picks[$urandom_range(0, 5)], $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? picks[$urandom_range(1, 5)] : -1,
              $urandom_range(0, 5));
      run_cmd("rand", 2'($urandom), 8'($urandom), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
